burst_receiver: RTL and testbench
=================================

Name: burst_receiver

Overview:
- Slave-side endpoint of the burst path. Accepts one AXI-style write burst (address channel, then data channel) from an upstream sender and assembles it into a single flat transaction slot.
- Hands the slot to the local consumer over a valid/ready port, then returns a write response (B channel) to the sender.
- One transaction in flight; new address accepted only when idle.

Parameters:
- ID_WIDTH, 4, width of awid/wid/bid
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, width of one data beat; STRB_WIDTH = DATA_WIDTH/8
- MAX_BEATS, 16, slot capacity in beats; LEN_WIDTH = 8
- TIMEOUT_CYCLES, 64, idle-W watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- awvalid, awready  in/out  1  address handshake
- awid  in  ID_WIDTH  burst ID
- awaddr  in  ADDR_WIDTH  start address
- awlen  in  LEN_WIDTH  beats-1
- awsize  in  3  bytes/beat code
- awburst  in  2  burst type
- awuser  in  2  routing tag, stored verbatim
- wvalid, wready  in/out  1  data handshake
- wid  in  ID_WIDTH  data ID
- wdata  in  DATA_WIDTH  beat data
- wstrb  in  STRB_WIDTH  byte strobes
- wlast  in  1  final beat marker
- bvalid, bready  out/in  1  response handshake
- bid  out  ID_WIDTH  response ID
- bresp  out  2  00 OKAY, 10 SLVERR
- out_valid, out_ready  out/in  1  slot handshake
- out_id, out_addr, out_len, out_size, out_burst, out_user  out  matching AW fields  stored header
- out_data  out  MAX_BEATS*DATA_WIDTH  beat k at [k*DATA_WIDTH +: DATA_WIDTH]
- out_strb  out  MAX_BEATS*STRB_WIDTH  beat k at [k*STRB_WIDTH +: STRB_WIDTH]
- out_err  out  1  burst was malformed (same value as bresp[1])

Behaviour:
- Reset: state=IDLE. All outputs 0, including awready, wready, bvalid, out_valid, out_data, out_strb, bresp and out_err. Beat counter 0. A reset mid-burst discards the partial slot.
- FSM states:
  - IDLE: awready=1.
    - On awvalid&awready: latch the header and clear data/strb/err/counter, then go to DATA.
  - DATA: wready = wvalid & (wid==latched awid). A beat with a mismatched wid is stalled, never dropped.
    - On an accepted beat with cnt<MAX_BEATS: store it at slot cnt, then cnt+1.
    - Go to DELIVER when the beat is the last one, i.e. wlast=1 or cnt==awlen.
  - DELIVER: out_valid=1 with stable outputs. Go to RESP on out_ready.
  - RESP: bvalid=1, bid=latched awid, bresp={err,1'b0}. Go to IDLE on bready.
- Latency:
  - Header registered 1 cycle after the AW handshake.
  - out_valid asserted the cycle after the last W handshake.
  - bvalid asserted the cycle after the out handshake.
  - awready reasserted the cycle after the B handshake.
  - Minimum turnaround for a 1-beat burst with all readies high: 4 cycles.
- Error rules (err is sticky for the burst; all are otherwise completed normally):
  - Early wlast (cnt<awlen): burst ends, unwritten slots stay 0, err=1.
  - Missing wlast at cnt==awlen: beat accepted as last, err=1.
  - awlen>=MAX_BEATS: all beats are handshaked, but beats with cnt>=MAX_BEATS are discarded, err=1.
- Simultaneous events:
  - awvalid outside IDLE is ignored (awready=0).
  - wvalid outside DATA gets wready=0.
- Width rules: cnt is LEN_WIDTH+1 bits, so it never wraps within a legal burst.

Optional Feature:
- BURST_RECV_TIMEOUT_EN defined:
  - A watchdog counts consecutive DATA cycles with no accepted W beat.
  - On reaching TIMEOUT_CYCLES it forces err=1 and moves to DELIVER with the partial slot.
  - The counter is cleared on every accepted beat and on state entry.
- Not defined: no watchdog logic; DATA waits indefinitely.

Test Plan:
- Single beat: AW id=3, addr=0x100, len=0; W data=0xDEADBEEF, strb=0xF, wlast=1, all readies high.
  - Expected: out_valid 1 cycle after the W handshake, out_data[31:0]=0xDEADBEEF, out_len=0.
  - Then bvalid with bid=3, bresp=00; awready back 4 cycles after AW.
- 4-beat burst (len=3, data 1..4) with wid=5 mismatching awid=2 for 3 cycles, then wid=2.
  - Expected: wready=0 during the mismatch, no beats stored.
  - Then beats land in slots 0..3, bresp=00.
- Early wlast on beat 2 of len=3.
  - Expected: slots 2..3 stay 0, out_err=1, bresp=10.
- Backpressure: out_ready held 0 for 5 cycles, then bready held 0 for 3 cycles.
  - Expected: out_* stable throughout; bvalid only after the out handshake; awready=0 until the B handshake.
- awlen=20 with MAX_BEATS=16.
  - Expected: 21 beats handshaked, slots hold beats 0..15, bresp=10.
  - Reset asserted mid-DATA in a second run → next cycle state IDLE, all outputs 0.
- With BURST_RECV_TIMEOUT_EN, TIMEOUT_CYCLES=64: 1 beat of len=3, then wvalid=0.
  - Expected: out_valid exactly 64 cycles after the last accepted beat, out_err=1.

Source files
------------

// File: rtl/burst_receiver.sv
// rtl/burst_receiver.sv - single-slot AXI-style write burst receiver; optional watchdog under BURST_RECV_TIMEOUT_EN
module burst_receiver #(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [ID_WIDTH-1:0]               awid,
    input  logic [ADDR_WIDTH-1:0]             awaddr,
    input  logic [LEN_WIDTH-1:0]              awlen,
    input  logic [2:0]                        awsize,
    input  logic [1:0]                        awburst,
    input  logic [1:0]                        awuser,
    input  logic                              wvalid,
    output logic                              wready,
    input  logic [ID_WIDTH-1:0]               wid,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [STRB_WIDTH-1:0]             wstrb,
    input  logic                              wlast,
    output logic                              bvalid,
    input  logic                              bready,
    output logic [ID_WIDTH-1:0]               bid,
    output logic [1:0]                        bresp,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ID_WIDTH-1:0]               out_id,
    output logic [ADDR_WIDTH-1:0]             out_addr,
    output logic [LEN_WIDTH-1:0]              out_len,
    output logic [2:0]                        out_size,
    output logic [1:0]                        out_burst,
    output logic [1:0]                        out_user,
    output logic [MAX_BEATS*DATA_WIDTH-1:0]   out_data,
    output logic [MAX_BEATS*STRB_WIDTH-1:0]   out_strb,
    output logic                              out_err
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DELIVER, S_RESP} state_t;

    localparam logic [LEN_WIDTH:0] MAX_CNT = (LEN_WIDTH+1)'(MAX_BEATS);

    state_t                            state_q, state_d;
    logic [ID_WIDTH-1:0]               id_q;
    logic [ADDR_WIDTH-1:0]             addr_q;
    logic [LEN_WIDTH-1:0]              len_q;
    logic [2:0]                        size_q;
    logic [1:0]                        burst_q;
    logic [1:0]                        user_q;
    logic [MAX_BEATS*DATA_WIDTH-1:0]   data_q;
    logic [MAX_BEATS*STRB_WIDTH-1:0]   strb_q;
    logic                              err_q;
    logic [LEN_WIDTH:0]                cnt_q;
    logic                              aw_fire, w_fire, at_len, w_last, w_err, wd_expire;

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign at_len  = (cnt_q == {1'b0, len_q});
    assign w_last  = wlast | at_len;
    // Early wlast, missing wlast and oversize bursts all mark the burst bad.
    assign w_err   = (wlast != at_len) | ({1'b0, len_q} >= MAX_CNT);

`ifdef BURST_RECV_TIMEOUT_EN
    logic [31:0] wd_q;

    // Expires so that out_valid rises TIMEOUT_CYCLES cycles after the last accepted beat.
    assign wd_expire = (state_q == S_DATA) && !w_fire && ((wd_q + 32'd2) >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n || state_q != S_DATA || w_fire) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 32'd1;
        end
    end
`else
    assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (aw_fire) state_d = S_DATA;
            S_DATA:    if ((w_fire && w_last) || wd_expire) state_d = S_DELIVER;
            S_DELIVER: if (out_ready) state_d = S_RESP;
            S_RESP:    if (bready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            user_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (aw_fire) begin
                id_q    <= awid;
                addr_q  <= awaddr;
                len_q   <= awlen;
                size_q  <= awsize;
                burst_q <= awburst;
                user_q  <= awuser;
                data_q  <= '0;
                strb_q  <= '0;
                err_q   <= 1'b0;
                cnt_q   <= '0;
            end
            if (w_fire) begin
                cnt_q <= cnt_q + 1'b1;
                // Beats past slot capacity still handshake but match no slot here.
                for (int k = 0; k < MAX_BEATS; k++) begin
                    if (cnt_q == (LEN_WIDTH+1)'(k)) begin
                        data_q[k*DATA_WIDTH +: DATA_WIDTH] <= wdata;
                        strb_q[k*STRB_WIDTH +: STRB_WIDTH] <= wstrb;
                    end
                end
                if (w_err) err_q <= 1'b1;
            end
            if (wd_expire) err_q <= 1'b1;
        end
    end

    assign awready   = (state_q == S_IDLE) & rst_n;
    assign wready    = (state_q == S_DATA) & wvalid & (wid == id_q);
    assign out_valid = (state_q == S_DELIVER);
    assign bvalid    = (state_q == S_RESP);
    assign bid       = id_q;
    assign bresp     = {err_q, 1'b0};
    assign out_id    = id_q;
    assign out_addr  = addr_q;
    assign out_len   = len_q;
    assign out_size  = size_q;
    assign out_burst = burst_q;
    assign out_user  = user_q;
    assign out_data  = data_q;
    assign out_strb  = strb_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_burst_receiver.sv
// tb/tb_burst_receiver.sv - randomized self-checking bench for burst_receiver with a burst-level model
module tb_burst_receiver;
    localparam int IDW = 4, AW = 32, DW = 32, SW = 4, MB = 16, LW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready, out_valid, out_ready, out_err;
    logic [IDW-1:0]  awid, wid, bid, out_id;
    logic [AW-1:0]   awaddr, out_addr;
    logic [LW-1:0]   awlen, out_len;
    logic [2:0]      awsize, out_size;
    logic [1:0]      awburst, awuser, bresp, out_burst, out_user;
    logic [DW-1:0]   wdata;
    logic [SW-1:0]   wstrb;
    logic [MB*DW-1:0] out_data;
    logic [MB*SW-1:0] out_strb;

    burst_receiver #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_addr(out_addr),
        .out_len(out_len), .out_size(out_size), .out_burst(out_burst), .out_user(out_user),
        .out_data(out_data), .out_strb(out_strb), .out_err(out_err)
    );

    int checks = 0;
    int errors = 0;

    // Expected transaction for the burst currently in flight.
    bit              m_check = 1'b0;
    logic [IDW-1:0]  m_id;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic [2:0]      m_size;
    logic [1:0]      m_burst, m_user;
    logic [DW-1:0]   m_data [MB];
    logic [SW-1:0]   m_strb [MB];
    logic            m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_check && rst_n) begin
            if (out_valid) begin
                chk("out_id", 64'(out_id), 64'(m_id));
                chk("out_addr", 64'(out_addr), 64'(m_addr));
                chk("out_len", 64'(out_len), 64'(m_len));
                chk("out_size", 64'(out_size), 64'(m_size));
                chk("out_burst", 64'(out_burst), 64'(m_burst));
                chk("out_user", 64'(out_user), 64'(m_user));
                chk("out_err", 64'(out_err), 64'(m_err));
                for (int k = 0; k < MB; k++) begin
                    chk("out_data", 64'(out_data[k*DW +: DW]), 64'(m_data[k]));
                    chk("out_strb", 64'(out_strb[k*SW +: SW]), 64'(m_strb[k]));
                end
            end
            if (bvalid) begin
                chk("bid", 64'(bid), 64'(m_id));
                chk("bresp", 64'(bresp), 64'({m_err, 1'b0}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_awready"}, 64'(awready), 64'd0);
        chk({tag, "_wready"}, 64'(wready), 64'd0);
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data_zero"}, 64'(out_data == '0), 64'd1);
        chk({tag, "_out_strb_zero"}, 64'(out_strb == '0), 64'd1);
        chk({tag, "_bresp"}, 64'(bresp), 64'd0);
        chk({tag, "_out_err"}, 64'(out_err), 64'd0);
        chk({tag, "_hdr_zero"}, 64'({bid, out_id, out_addr, out_len, out_size, out_burst, out_user} == '0), 64'd1);
    endtask

    // mode 0: wlast on beat len; 1: early wlast on beat early_at; 2: wlast never driven.
    // dmode 0: random data; 1: beat i carries i+1; 2: single 0xDEADBEEF at 0x100.
    // stall >= 0 mismatched-wid cycles before beat 0 only; < 0 random before each beat.
    // out_hold/b_hold >= 0 cycles of ready low before asserting; < 0 random ready.
    task automatic run_burst(input logic [IDW-1:0] id, input logic [LW-1:0] len, input int mode,
                             input int early_at, input int dmode, input int stall,
                             input int out_hold, input int b_hold);
        logic [DW-1:0] dat [$];
        logic [SW-1:0] stb [$];
        int n_acc, ns, cyc;
        bit done;
        n_acc = (mode == 1) ? early_at + 1 : int'(len) + 1;
        for (int i = 0; i < n_acc; i++) begin
            dat.push_back((dmode == 1) ? DW'(i + 1) : (dmode == 2) ? 32'hDEADBEEF : $urandom);
            stb.push_back((dmode == 0) ? SW'($urandom) : 4'hF);
        end
        m_id = id;
        m_addr = (dmode == 2) ? 32'h100 : $urandom;
        m_len = len;
        m_size = 3'($urandom);
        m_burst = 2'($urandom);
        m_user = 2'($urandom);
        for (int k = 0; k < MB; k++) begin
            m_data[k] = (k < n_acc) ? dat[k] : '0;
            m_strb[k] = (k < n_acc) ? stb[k] : '0;
        end
        m_err = (mode != 0) || (len >= MB);
        m_check = 1'b1;

        awvalid = 1'b1; awid = id; awaddr = m_addr; awlen = len;
        awsize = m_size; awburst = m_burst; awuser = m_user;
        @(negedge clk);
        chk("awready_idle", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0;

        for (int i = 0; i < n_acc; i++) begin
            ns = (stall < 0) ? $urandom_range(0, 2) : ((i == 0) ? stall : 0);
            for (int s = 0; s < ns; s++) begin
                wvalid = 1'b1; wid = id ^ IDW'($urandom_range(1, 15));
                wdata = $urandom; wstrb = SW'($urandom); wlast = 1'($urandom);
                awvalid = 1'($urandom); awid = IDW'($urandom); awaddr = $urandom; awlen = LW'($urandom);
                @(negedge clk);
                chk("wready_mismatch", 64'(wready), 64'd0);
                chk("awready_busy", 64'(awready), 64'd0);
                tick();
            end
            wvalid = 1'b1; wid = id; wdata = dat[i]; wstrb = stb[i];
            wlast = (mode == 0 && i == int'(len)) || (mode == 1 && i == early_at);
            awvalid = 1'($urandom); awid = IDW'($urandom);
            @(negedge clk);
            chk("wready_match", 64'(wready), 64'd1);
            tick();
        end
        awvalid = 1'b0; wlast = 1'b0;

        // W stays offered with the right id: it must be refused outside DATA.
        out_ready = (out_hold < 0) ? 1'($urandom) : (out_hold == 0);
        @(negedge clk);
        chk("out_valid_latency", 64'(out_valid), 64'd1);
        cyc = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            chk("wready_outside_data", 64'(wready), 64'd0);
            chk("bvalid_before_out", 64'(bvalid), 64'd0);
            chk("awready_deliver", 64'(awready), 64'd0);
            if (out_valid && out_ready) done = 1'b1;
            tick();
            cyc++;
            if (!done) begin
                out_ready = (out_hold < 0) ? 1'($urandom) : (cyc >= out_hold);
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        chk("out_handshake", 64'(done), 64'd1);

        bready = (b_hold < 0) ? 1'($urandom) : (b_hold == 0);
        @(negedge clk);
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        cyc = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            chk("out_valid_in_resp", 64'(out_valid), 64'd0);
            chk("awready_resp", 64'(awready), 64'd0);
            chk("wready_resp", 64'(wready), 64'd0);
            if (bvalid && bready) done = 1'b1;
            tick();
            cyc++;
            if (!done) begin
                bready = (b_hold < 0) ? 1'($urandom) : (cyc >= b_hold);
                @(negedge clk);
            end
        end
        bready = 1'b0; wvalid = 1'b0;
        chk("b_handshake", 64'(done), 64'd1);
        @(negedge clk);
        chk("awready_after_b", 64'(awready), 64'd1);
        chk("bvalid_after_b", 64'(bvalid), 64'd0);
        tick();
    endtask

    initial begin
        int cyc;
        bit done;
        rst_n = 1'b0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awuser = 0;
        wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_post_reset", 64'(awready), 64'd1);
        tick();

        run_burst(4'd3, 8'd0, 0, 0, 2, 0, 0, 0);
        chk("single_data", 64'(out_data[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
        chk("single_addr", 64'(out_addr), 64'h100);
        chk("single_len", 64'(out_len), 64'd0);
        chk("single_bresp", 64'(bresp), 64'd0);

        run_burst(4'd2, 8'd3, 0, 0, 1, 3, 0, 0);
        chk("wid_stall_slot3", 64'(out_data[3*DW +: DW]), 64'd4);
        chk("wid_stall_bresp", 64'(bresp), 64'd0);

        run_burst(4'd6, 8'd3, 1, 1, 1, 0, 0, 0);
        chk("early_slot1", 64'(out_data[1*DW +: DW]), 64'd2);
        chk("early_slot2", 64'(out_data[2*DW +: DW]), 64'd0);
        chk("early_slot3", 64'(out_data[3*DW +: DW]), 64'd0);
        chk("early_bresp", 64'(bresp), 64'b10);

        run_burst(4'd1, 8'd2, 0, 0, 0, 0, 5, 3);

        run_burst(4'd9, 8'd20, 0, 0, 1, 0, 0, 0);
        chk("oversize_slot15", 64'(out_data[15*DW +: DW]), 64'd16);
        chk("oversize_err", 64'(out_err), 64'd1);

        run_burst(4'd4, 8'd2, 2, 0, 1, 0, 0, 0);
        chk("missing_wlast_err", 64'(out_err), 64'd1);

        m_check = 1'b0;
        awvalid = 1'b1; awid = 4'd5; awaddr = 32'h200; awlen = 8'd7;
        @(negedge clk);
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wid = 4'd5; wdata = 32'hA5A5_0001; wstrb = 4'hF; wlast = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("mid_burst_reset");
        tick();
        wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_mid_reset", 64'(awready), 64'd1);
        tick();

        for (int t = 0; t < 40; t++) begin
            logic [LW-1:0] l;
            int md, ea;
            l = ($urandom_range(0, 5) == 0) ? LW'($urandom_range(16, 22)) : LW'($urandom_range(0, 15));
            md = (l == 0) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 2);
            ea = (l == 0) ? 0 : $urandom_range(0, int'(l) - 1);
            run_burst(IDW'($urandom), l, md, ea, 0, -1, -1, -1);
        end

`ifdef BURST_RECV_TIMEOUT_EN
        m_check = 1'b0;
        awvalid = 1'b1; awid = 4'd7; awaddr = 32'h300; awlen = 8'd3;
        @(negedge clk);
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wid = 4'd7; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b0;
        @(negedge clk);
        tick();
        wvalid = 1'b0;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) done = 1'b1;
            else tick();
        end
        chk("timeout_latency", 64'(cyc), 64'd64);
        chk("timeout_err", 64'(out_err), 64'd1);
        chk("timeout_data", 64'(out_data[0 +: DW]), 64'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; bready = 1'b1;
        @(negedge clk);
        chk("timeout_bresp", 64'({bvalid, bresp}), 64'b110);
        tick();
        bready = 1'b0;
`else
        cyc = 0; done = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
